// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_if
//  Description : Issue / write-back bundle between the register-file read
//                ports, the ALU execute stage and the register-file write port.
//                master = issuing side, slave = execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_exec_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd_in;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              reg_write;
    logic [ADDR_W-1:0] rd_out;
    logic [WIDTH-1:0]  result;
    logic              flag_z;
    logic              flag_c;

    modport master (
        output start, op, rd_in, a, b,
        input  busy, reg_write, rd_out, result, flag_z, flag_c
    );

    modport slave (
        input  start, op, rd_in, a, b,
        output busy, reg_write, rd_out, result, flag_z, flag_c
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute stage feeding the 8x8 register-file write port.
//                Single-cycle ADD/SUB/AND/OR/XOR/SHL/PASSB; optional
//                iterative shift-add MUL with a start/busy handshake.
//                Optional feature macro: ALU_MUL_EN (defined = MUL state and
//                datapath present; undefined = op 110 behaves as PASSB).
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_stage #(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int MUL_STEPS = WIDTH
) (
    input wire        clk,
    input wire        rst,
    alu_exec_if.slave bus
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;

    // A zero-step multiply would never complete; reject it at elaboration.
    if (MUL_STEPS < 1) begin : g_bad_mul_steps
        $error("alu_exec_stage: MUL_STEPS must be at least 1");
    end

    // ------------------------------------------------------------------
    // Write-back registers
    // ------------------------------------------------------------------
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] rd_out_q,    rd_out_d;
    logic [WIDTH-1:0]  result_q,    result_d;
    logic              flag_z_q,    flag_z_d;
    logic              flag_c_q,    flag_c_d;

    // Hooks between the (optional) multiplier and the write-back logic
    logic              w_single;
    logic              w_mul_done;
    logic [WIDTH-1:0]  w_mul_res;
    logic              w_mul_c;
    logic [ADDR_W-1:0] w_mul_rd;

    // ------------------------------------------------------------------
    // Single-cycle ALU datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;

    // Combinational result/carry for the non-iterative opcodes; bit WIDTH of
    // the extended shift is the last bit pushed out (0 for a zero shift).
    always_comb begin
        w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff    = {1'b0, bus.a} - {1'b0, bus.b};
        w_shl     = {1'b0, bus.a} << bus.b[2:0];
        w_alu_res = bus.b;
        w_alu_c   = 1'b0;
        case (bus.op)
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
            end
            c_OP_AND: w_alu_res = bus.a & bus.b;
            c_OP_OR:  w_alu_res = bus.a | bus.b;
            c_OP_XOR: w_alu_res = bus.a ^ bus.b;
            c_OP_SHL: begin
                w_alu_res = w_shl[WIDTH-1:0];
                w_alu_c   = w_shl[WIDTH];
            end
            default: begin
                // PASSB, and MUL when the multiplier is not built
                w_alu_res = bus.b;
                w_alu_c   = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    // ------------------------------------------------------------------
    // Iterative shift-add multiplier
    // ------------------------------------------------------------------
    localparam logic [2:0] c_OP_MUL = 3'b110;
    localparam int         CNT_W    = $clog2(MUL_STEPS + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]  acc_q,    acc_d;
    logic [WIDTH-1:0]    mcand_q,  mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [ADDR_W-1:0]   rd_lat_q, rd_lat_d;
    logic [2*WIDTH-1:0]  w_addend;

    // Next-state: latch operands on MUL issue, then one shift-add step per clock.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rd_lat_d = rd_lat_q;
        w_addend = '0;
        if (state_q == S_IDLE) begin
            if (bus.start && (bus.op == c_OP_MUL)) begin
                mcand_d  = bus.a;
                mplier_d = bus.b;
                rd_lat_d = bus.rd_in;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_MUL;
            end
        end else begin
            if (mplier_q[0]) begin
                w_addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
            end
            acc_d    = acc_q + w_addend;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(MUL_STEPS)) begin
                state_d = S_IDLE;
            end
        end
    end

    // Multiplier state; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rd_lat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rd_lat_q <= rd_lat_d;
        end
    end

    assign bus.busy   = (state_q == S_MUL);
    assign w_single   = (state_q == S_IDLE) && bus.start && (bus.op != c_OP_MUL);
    assign w_mul_done = (state_q == S_MUL) && (cnt_d == CNT_W'(MUL_STEPS));
    assign w_mul_res  = acc_d[WIDTH-1:0];
    assign w_mul_c    = |acc_d[2*WIDTH-1:WIDTH];
    assign w_mul_rd   = rd_lat_q;
`else
    // No multiplier: every issue is single-cycle and the stage is never busy.
    assign bus.busy   = 1'b0;
    assign w_single   = bus.start;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = '0;
    assign w_mul_c    = 1'b0;
    assign w_mul_rd   = '0;
`endif

    // Write-back: pulse reg_write for one cycle; otherwise hold result/flags.
    always_comb begin
        reg_write_d = 1'b0;
        rd_out_d    = rd_out_q;
        result_d    = result_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        if (w_mul_done) begin
            reg_write_d = 1'b1;
            rd_out_d    = w_mul_rd;
            result_d    = w_mul_res;
            flag_c_d    = w_mul_c;
        end else if (w_single) begin
            reg_write_d = 1'b1;
            rd_out_d    = bus.rd_in;
            result_d    = w_alu_res;
            flag_c_d    = w_alu_c;
        end
        if (reg_write_d) begin
            flag_z_d = (result_d == '0);
        end
    end

    // Write-back registers with immediate clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            rd_out_q    <= '0;
            result_q    <= '0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
        end else begin
            reg_write_q <= reg_write_d;
            rd_out_q    <= rd_out_d;
            result_q    <= result_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
        end
    end

    assign bus.reg_write = reg_write_q;
    assign bus.rd_out    = rd_out_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;

endmodule
`default_nettype wire
